// File: rtl/dmem_lane_ctrl.sv
// Word-organised data memory with a valid/ready byte-addressed request port, lane stores,
// extended loads, error reporting and an optional post-reset zero-clear sweep.
module dmem_lane_ctrl #(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 11,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   cnt_q;
  logic [31:0]       mem [DEPTH];

  logic [IdxW-1:0]   idx;
  logic              range_err;
  logic              req_err;
  logic              accept;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign idx       = req_addr[IdxW+1:2];
  assign req_ready = (state_q == StReady);
  assign accept    = req_valid && req_ready;

  // Address bits above the word index only exist when ADDR_W leaves headroom.
  if (ADDR_W > IdxW + 2) begin : g_range
    assign range_err = |req_addr[ADDR_W-1:IdxW+2];
  end else begin : g_no_range
    assign range_err = 1'b0;
  end

  always_comb begin
    req_err = range_err;
    unique case (req_size)
      2'b00:   req_err = req_err || (req_addr[1:0] != 2'b00);
      2'b01:   req_err = req_err || req_addr[0];
      2'b10:   req_err = req_err;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    be         = 4'b0000;
    wdata_lane = req_wdata;
    unique case (req_size)
      2'b00: be = 4'b1111;
      2'b01: begin
        be         = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b0001 << req_addr[1:0];
        wdata_lane = {4{req_wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rd_word   = mem[idx];
    rd_shift  = rd_word >> {req_addr[1:0], 3'b000};
    rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    unique case (req_size)
      2'b01:   load_data = req_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0000, rd_half};
      2'b10:   load_data = req_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                      : {24'h000000, rd_shift[7:0]};
      default: load_data = rd_word;
    endcase
  end

  // Storage has no reset so contents survive reset when the clear sweep is disabled.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RESET ? StClear : StReady;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_err   <= req_err;
        resp_rdata <= (req_err || req_we) ? 32'h0 : load_data;
      end
      case (state_q)
        StClear: begin
          cnt_q <= cnt_q + IdxW'(1);
          if (cnt_q == IdxW'(DEPTH - 1)) state_q <= StReady;
        end
        default: state_q <= StReady;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl: one clearing instance and one non-clearing instance.
module tb_dmem_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst_n1, rst_n0;
  logic        valid1, valid0;
  logic        we, sgn;
  logic [1:0]  size;
  logic [10:0] addr;
  logic [31:0] wdata;

  logic        ready1, rv1, err1;
  logic [31:0] rdata1;
  logic        ready0, rv0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  logic        pend      = 1'b0;
  logic        pend_err  = 1'b0;
  logic [31:0] pend_data = 32'h0;
  string       pend_tag  = "none";

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.DEPTH(32), .ADDR_W(11), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n1), .req_valid(valid1), .req_ready(ready1), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1)
  );

  dmem_lane_ctrl #(.DEPTH(32), .ADDR_W(11), .CLEAR_ON_RESET(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .req_valid(valid0), .req_ready(ready0), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [10:0] a, input logic [31:0] wd);
    we = w; size = sz; sgn = sg; addr = a; wdata = wd;
  endtask

  // One negedge step on the clearing instance: check the response to the previous request,
  // then present the next one (pipelined, so consecutive calls are back-to-back).
  task automatic cycle(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [10:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_data, input string tag);
    @(negedge clk);
    chk({pend_tag, "_valid"}, {31'b0, rv1}, {31'b0, pend});
    if (pend) begin
      chk({pend_tag, "_err"}, {31'b0, err1}, {31'b0, pend_err});
      chk({pend_tag, "_data"}, rdata1, pend_data);
    end
    if (v) chk({tag, "_ready"}, {31'b0, ready1}, 32'h1);
    valid1 = v;
    drive(w, sz, sg, a, wd);
    pend      = v;
    pend_err  = e_err;
    pend_data = e_data;
    pend_tag  = tag;
  endtask

  task automatic flush();
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 11'h000, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    rst_n1 = 1'b0; rst_n0 = 1'b0; valid1 = 1'b0; valid0 = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 11'h000, 32'h0);
    repeat (2) @(negedge clk);

    chk("rst_valid1", {31'b0, rv1}, 32'h0);
    chk("rst_err1", {31'b0, err1}, 32'h0);
    chk("rst_data1", rdata1, 32'h0);
    chk("rst_ready1", {31'b0, ready1}, 32'h0);
    chk("rst_valid0", {31'b0, rv0}, 32'h0);
    chk("rst_data0", rdata0, 32'h0);

    // Clear sweep: ready low for DEPTH cycles after release.
    rst_n1 = 1'b1; rst_n0 = 1'b1;
    chk("noclr_ready0", {31'b0, ready0}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      chk("clr_ready_low", {31'b0, ready1}, 32'h0);
      @(negedge clk);
    end
    chk("clr_ready_high", {31'b0, ready1}, 32'h1);
    for (int i = 0; i < 32; i++)
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'(i * 4), 32'h0, 1'b0, 32'h0, "clr_ld");
    flush();

    // Lane stores, back-to-back.
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0, 32'h0, "st_w");
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 11'h013, 32'h0000005A, 1'b0, 32'h0, "st_b");
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h010, 32'h0, 1'b0, 32'h5AADBEEF, "ld_w");
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 11'h012, 32'hFFFF1234, 1'b0, 32'h0, "st_h_hi");
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h010, 32'h0, 1'b0, 32'h1234BEEF, "ld_w_hi");

    // Load extension.
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 11'h020, 32'h80F07F01, 1'b0, 32'h0, "st_w2");
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 11'h022, 32'h0, 1'b0, 32'hFFFFFFF0, "ld_bs");
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 11'h022, 32'h0, 1'b0, 32'h000000F0, "ld_bu");
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 11'h021, 32'h0, 1'b0, 32'h0000007F, "ld_bs_pos");
    cycle(1'b1, 1'b0, 2'b01, 1'b1, 11'h022, 32'h0, 1'b0, 32'hFFFF80F0, "ld_hs");
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 11'h020, 32'h0, 1'b0, 32'h00007F01, "ld_hu");

    // Errors leave memory untouched.
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 11'h021, 32'h0, 1'b1, 32'h0, "err_half");
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 11'h022, 32'h11111111, 1'b1, 32'h0, "err_word");
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 11'h000, 32'h0, 1'b1, 32'h0, "err_size");
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h020, 32'h0, 1'b0, 32'h80F07F01, "ld_after_err");
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h080, 32'h0, 1'b1, 32'h0, "err_range_ld");
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 11'h400, 32'h000000AA, 1'b1, 32'h0, "err_range_st");
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h000, 32'h0, 1'b0, 32'h0, "ld_after_range");
    flush();

    // Request held through a fresh clear sweep is accepted only once READY.
    @(negedge clk);
    rst_n1 = 1'b0;
    valid1 = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 11'h004, 32'h12345678);
    @(negedge clk);
    rst_n1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("clr_no_resp", {31'b0, rv1}, 32'h0);
      @(negedge clk);
    end
    @(negedge clk);
    valid1 = 1'b0;
    chk("held_st_valid", {31'b0, rv1}, 32'h1);
    chk("held_st_err", {31'b0, err1}, 32'h0);
    pend = 1'b0;
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h004, 32'h0, 1'b0, 32'h12345678, "ld_held");
    flush();
    @(negedge clk);
    chk("one_resp_only", {31'b0, rv1}, 32'h0);

    // In-flight response dropped by reset; clearing instance wipes memory again.
    valid1 = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 11'h004, 32'h0);
    @(posedge clk);
    #1 rst_n1 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    chk("drop1_in_rst", {31'b0, rv1}, 32'h0);
    @(negedge clk);
    rst_n1 = 1'b1;
    chk("drop1_ready", {31'b0, ready1}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("drop1_after", {31'b0, rv1}, 32'h0);
    end
    repeat (29) @(negedge clk);
    chk("reclr_ready", {31'b0, ready1}, 32'h1);
    pend = 1'b0;
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 11'h004, 32'h0, 1'b0, 32'h0, "ld_recleared");
    flush();

    // Non-clearing instance keeps its contents across reset.
    @(negedge clk);
    valid0 = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 11'h008, 32'hCAFEF00D);
    @(negedge clk);
    valid0 = 1'b0;
    chk("st0_valid", {31'b0, rv0}, 32'h1);
    chk("st0_err", {31'b0, err0}, 32'h0);
    @(negedge clk);
    valid0 = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 11'h008, 32'h0);
    @(posedge clk);
    #1 rst_n0 = 1'b0; valid0 = 1'b0;
    @(negedge clk);
    chk("drop0_in_rst", {31'b0, rv0}, 32'h0);
    @(negedge clk);
    rst_n0 = 1'b1;
    chk("drop0_ready", {31'b0, ready0}, 32'h1);
    @(negedge clk);
    chk("drop0_after", {31'b0, rv0}, 32'h0);
    valid0 = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 11'h008, 32'h0);
    @(negedge clk);
    valid0 = 1'b0;
    chk("keep0_valid", {31'b0, rv0}, 32'h1);
    chk("keep0_data", rdata0, 32'hCAFEF00D);
    @(negedge clk);
    chk("keep0_single", {31'b0, rv0}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
Parametrised successor to the single-cycle word data memory used by the CPU MEM stage. Provides a valid/ready request port with byte-address decode and byte/half/word stores into lanes. Adds signed/unsigned load extension, misalignment and range error reporting, a registered one-cycle read response, and an optional post-reset zero-clear sequence.

Parameters:
DEPTH, 32, number of 32-bit words; a power of two, at least 2.
ADDR_W, 11, byte-address width; must satisfy ADDR_W >= clog2(DEPTH)+2.
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = contents retained/undefined.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
req_signed  in  1  load sign-extend (1) / zero-extend (0); ignored for word and stores
req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2], lane = req_addr[1:0]
req_wdata  in  32  store data; byte in [7:0], half in [15:0]
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  request rejected (misaligned, reserved size, index out of range)

Behaviour:
- Reset: one clock, reset asynchronous active-low. On assertion resp_valid=0, resp_rdata=0, resp_err=0, clear counter=0. State goes to CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- States: CLEAR and READY. req_ready = (state==READY), so it is 0 throughout CLEAR.
- CLEAR: writes 0 to word[cnt] each cycle, cnt counting 0..DEPTH-1. After the cycle that writes word DEPTH-1, go to READY, so req_ready rises DEPTH cycles after rst_n deasserts. Any req_valid during CLEAR is ignored.
- READY: a request is accepted on the rising edge where req_valid & req_ready. Full throughput, one request per cycle, no bubbles.
- Latency: resp_valid=1 in exactly the cycle after acceptance and 0 otherwise. Every accepted request, load or store, gets exactly one response.
- Error check, applied on acceptance:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - index >= DEPTH is an error. Not reachable when ADDR_W = clog2(DEPTH)+2; otherwise the upper bits are checked.
  - On error: no memory change, resp_err=1, resp_rdata=0.
- Store lanes:
  - byte writes wdata[7:0] into byte lane addr[1:0].
  - half writes wdata[15:0] into bits [15:0] if addr[1]=0, else [31:16].
  - word writes all 32 bits.
  - Unselected bytes are unchanged. resp_rdata=0, resp_err=0.
- Load:
  - Selects the same lane as the store rules.
  - Byte/half are sign-extended if req_signed, else zero-extended.
  - Word is returned as stored.
  - Result is registered into resp_rdata.
- Back-to-back: a load accepted the cycle after a store to the same word returns the post-store value. No extra forwarding path is needed because the write completes at the acceptance edge.
- Loads with CLEAR_ON_RESET=0 of never-written words return X. The bench must not check these.
- Reset mid-operation: an in-flight response is dropped, with no resp_valid after reset release.
  - CLEAR_ON_RESET=1: clear restarts from word 0.
  - CLEAR_ON_RESET=0: memory contents are preserved across reset.
- Reset asserted mid-CLEAR: restart at cnt=0.
- resp_rdata and resp_err hold their last values while resp_valid=0. Only the resp_valid cycle is meaningful.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, DEPTH=32 -> req_ready=0 for 32 cycles, then 1. Word loads of addresses 0x000..0x07C all return 0x00000000.
2. Store word 0xDEADBEEF @0x010, then store byte 0x5A @0x013, then load word @0x010 -> resp_rdata=0x5AADBEEF, resp_err=0, one resp_valid per request, back-to-back.
3. Store word 0x80F07F01 @0x020. Load byte signed @0x022 -> 0xFFFFFFF0. Load byte unsigned @0x022 -> 0x000000F0. Load half signed @0x022 -> 0xFFFF80F0. Load half unsigned @0x020 -> 0x00007F01.
4. Load half @0x021, store word @0x022, req_size=11 @0x000 -> each gives resp_err=1, resp_rdata=0. A following word load @0x020 still returns 0x80F07F01.
5. Hold req_valid high during CLEAR with store 0x12345678 @0x004 -> no response during CLEAR. When the request is accepted after CLEAR, the store completes and a word load @0x004 returns 0x12345678.
6. Accept a load, then pull rst_n low for 1 cycle before the response edge -> resp_valid stays 0. With CLEAR_ON_RESET=0, previously stored data reads back unchanged after reset.
